// File: rtl/bit_packer.sv
// Bit-packing gearbox: joins IN_W-bit beats into one bit stream and emits OUT_W-bit words.
// A flush drains the buffered bits and tags the final, zero-padded word with OUT_LAST.
module bit_packer #(
  parameter int IN_W      = 10,
  parameter int OUT_W     = 32,
  parameter bit LSB_FIRST = 1'b0,
  parameter int FILL_W    = $clog2(OUT_W + IN_W)
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic [IN_W-1:0]   IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic              FLUSH,
  output logic [OUT_W-1:0]  OUT_DATA,
  output logic              OUT_VALID,
  output logic              OUT_LAST,
  input  logic              OUT_READY,
  output logic [FILL_W-1:0] FILL_LEVEL,
  output logic              FLUSH_BUSY
);

  localparam int ACC_W = OUT_W + IN_W - 1;
  localparam logic [FILL_W-1:0] OUT_W_F  = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] IN_W_F   = FILL_W'(IN_W);
  localparam logic [FILL_W-1:0] MSB_BASE = FILL_W'(OUT_W - 1);

  logic [ACC_W-1:0]  acc_r;
  logic [FILL_W-1:0] fill_r;
  logic [OUT_W-1:0]  out_data_r;
  logic              out_valid_r;
  logic              out_last_r;
  logic              flush_busy_r;

  logic              out_free_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              extract_s;
  logic [ACC_W-1:0]  in_ext_s;
  logic [ACC_W-1:0]  acc_nxt_s;
  logic [FILL_W-1:0] fill_nxt_s;
  logic [OUT_W-1:0]  word_s;
  logic              busy_nxt_s;
  logic              last_nxt_s;

  // Handshake qualifiers; IN_READY depends on registered state only.
  always_comb begin
    out_free_s = !out_valid_r || OUT_READY;
    in_ready_s = (fill_r < OUT_W_F) && !flush_busy_r;
    accept_s   = IN_VALID && in_ready_s;
    extract_s  = out_free_s &&
                 ((fill_r >= OUT_W_F) || (flush_busy_r && (fill_r != {FILL_W{1'b0}})));
  end

  // Accumulator keeps the oldest bit at the MSB (MSB mode) or LSB (LSB mode); unused bits stay zero,
  // so a partial remainder is already left/right-justified and zero-padded when extracted.
  always_comb begin
    in_ext_s   = ACC_W'(IN_DATA);
    acc_nxt_s  = acc_r;
    fill_nxt_s = fill_r;
    if (LSB_FIRST) begin
      word_s = acc_r[OUT_W-1:0];
    end else begin
      word_s = acc_r[ACC_W-1 -: OUT_W];
    end
    if (extract_s) begin
      if (LSB_FIRST) begin
        acc_nxt_s = acc_r >> OUT_W;
      end else begin
        acc_nxt_s = acc_r << OUT_W;
      end
      if (fill_r >= OUT_W_F) begin
        fill_nxt_s = fill_r - OUT_W_F;
      end else begin
        fill_nxt_s = {FILL_W{1'b0}};
      end
    end else if (accept_s) begin
      if (LSB_FIRST) begin
        acc_nxt_s = acc_r | (in_ext_s << fill_r);
      end else begin
        acc_nxt_s = acc_r | (in_ext_s << (MSB_BASE - fill_r));
      end
      fill_nxt_s = fill_r + IN_W_F;
    end else begin
      acc_nxt_s  = acc_r;
      fill_nxt_s = fill_r;
    end
  end

  // Flush bookkeeping: a new FLUSH is ignored while busy; busy ends when the buffer empties.
  always_comb begin
    last_nxt_s = flush_busy_r && (fill_nxt_s == {FILL_W{1'b0}});
    if (flush_busy_r) begin
      busy_nxt_s = (fill_nxt_s != {FILL_W{1'b0}});
    end else begin
      busy_nxt_s = FLUSH;
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc_r        <= {ACC_W{1'b0}};
      fill_r       <= {FILL_W{1'b0}};
      out_data_r   <= {OUT_W{1'b0}};
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      flush_busy_r <= 1'b0;
    end else begin
      acc_r        <= acc_nxt_s;
      fill_r       <= fill_nxt_s;
      flush_busy_r <= busy_nxt_s;
      if (extract_s) begin
        out_data_r  <= word_s;
        out_valid_r <= 1'b1;
        out_last_r  <= last_nxt_s;
      end else if (OUT_READY) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end

  assign IN_READY   = in_ready_s;
  assign OUT_DATA   = out_data_r;
  assign OUT_VALID  = out_valid_r;
  assign OUT_LAST   = out_last_r;
  assign FILL_LEVEL = fill_r;
  assign FLUSH_BUSY = flush_busy_r;

endmodule

// File: doc/bit_packer.md
Name: bit_packer

Overview:
- Parametrised bit-packing gearbox: accumulates IN_W-bit input beats into a continuous bit stream and emits OUT_W-bit words.
- Sits between narrow sample/symbol sources (e.g. 10-bit words) and the 32-bit transport-stream capture datapath.
- Valid/ready handshakes on both sides, MSB-first or LSB-first packing, and a flush that emits a zero-padded final word tagged LAST.

Parameters:
- IN_W, 10, input beat width; legal range 1 <= IN_W <= OUT_W.
- OUT_W, 32, output word width.
- LSB_FIRST, 0, packing order. 0: the first bit received lands in the output MSB. 1: the first beat lands in OUT_DATA[IN_W-1:0].
- FILL_W, $clog2(OUT_W+IN_W), width of the fill counter.

Ports:
- CLOCK  in  1  single clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IN_DATA  in  IN_W  input beat.
- IN_VALID  in  1  IN_DATA is valid.
- IN_READY  out  1  packer accepts a beat this cycle.
- FLUSH  in  1  single-cycle request to drain all buffered bits.
- OUT_DATA  out  OUT_W  packed word, registered.
- OUT_VALID  out  1  OUT_DATA is valid.
- OUT_LAST  out  1  word is the final word of a flush.
- OUT_READY  in  1  sink accepts OUT_DATA.
- FILL_LEVEL  out  FILL_W  number of buffered bits not yet emitted.
- FLUSH_BUSY  out  1  flush pending.

Behaviour:
- Reset (async, RESET_N=0): OUT_DATA=0, OUT_VALID=0, OUT_LAST=0, FILL_LEVEL=0, FLUSH_BUSY=0, accumulator cleared. A reset mid-word discards all buffered bits; no partial word is emitted.
- Accumulator width: OUT_W+IN_W-1 bits. FILL counts valid bits.
- IN_READY = (FILL < OUT_W) && !FLUSH_BUSY. IN_READY is a function of registered state only.
- Accept occurs when IN_VALID && IN_READY.
  - MSB mode: the beat is appended below the existing bits.
  - LSB mode: the beat is appended above the existing bits.
  - FILL += IN_W.
- Output register is free when OUT_VALID=0 or OUT_READY=1.
- Extraction occurs when FILL >= OUT_W and the output register is free.
  - The oldest OUT_W bits load into OUT_DATA, OUT_VALID=1, FILL -= OUT_W.
  - Remaining bits shift to the oldest position.
- Accept and extraction can never coincide, because accept requires FILL < OUT_W.
- Latency: the beat completing a word is accepted at edge N; OUT_VALID=1 after edge N+1 if the register is free.
- OUT_VALID is cleared on OUT_READY when no new extraction happens the same edge. Back-to-back words are allowed: extraction on the same edge as the handshake.
- OUT_DATA and OUT_LAST are held stable while OUT_VALID && !OUT_READY.
- Flush:
  - FLUSH sets FLUSH_BUSY on the next edge.
  - If FLUSH coincides with an accepted beat, the beat is included in the flush.
  - FLUSH asserted while FLUSH_BUSY=1 is ignored.
- While FLUSH_BUSY:
  - Full words drain normally.
  - When 0 < FILL < OUT_W and the register is free, emit the remainder. MSB mode: left-justified, zero-padded low. LSB mode: right-justified, zero-padded high. Set OUT_LAST=1 and FILL=0.
  - If a full-word extraction leaves FILL=0, that word carries OUT_LAST=1.
  - FLUSH_BUSY clears on the edge where FILL reaches 0.
  - If FILL=0 at flush start, FLUSH_BUSY clears next edge with no word and no LAST.
- OUT_LAST=0 on all non-final words.
- Accumulator sized so FILL never exceeds OUT_W+IN_W-1, so there is no overflow path.

Test Plan:
- MSB, IN_W=10/OUT_W=32, OUT_READY=1; beats 0x333, 0x0CC, 0x3E0, 0x3FF -> one word 0xCCCCCF83, OUT_LAST=0, OUT_VALID one cycle after 4th accept, FILL_LEVEL=8.
- Continue: pulse FLUSH -> word 0xFF000000, OUT_LAST=1, FILL_LEVEL=0, FLUSH_BUSY clears, IN_READY returns to 1.
- LSB_FIRST=1, same 4 beats then FLUSH -> words 0xFE033333 (LAST=0) then 0x000000FF (LAST=1).
- Backpressure: OUT_READY=0, feed 7 beats of 0x3FF -> first word 0xFFFFFFFF held stable; IN_READY drops when FILL=38; raise OUT_READY -> 2nd word 0xFFFFFFFF, FILL=6, input resumes.
- Flush with FILL=0, and FLUSH during FLUSH_BUSY -> no output word; FLUSH_BUSY high exactly one cycle; second FLUSH ignored.
- Assert RESET_N=0 with FILL=20 and OUT_VALID=1 -> all outputs 0 immediately (asynchronous); after release, beats 0x333 x4 produce only new-stream data (0xCCF33CCF), no stale bits.
